// File: rtl/cp_remover.sv
`default_nettype none
// cp_remover: strips the cyclic prefix from each OFDM symbol and buffers payload toward the FFT.
// Optional macro CP_REM_BACKOFF_EN advances the kept window CP_BACKOFF samples into the CP.
module cp_remover #(
   parameter int CP_LEN     = 16,
   parameter int FFT_LEN    = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int CP_BACKOFF = 4
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] DAT_I,
   input  logic        WE_I,
   input  logic        STB_I,
   input  logic        CYC_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I
);

   localparam int SYM_LEN = CP_LEN + FFT_LEN;
   localparam int CNT_W   = $clog2(SYM_LEN);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int FILL_W  = PTR_W + 1;
`ifdef CP_REM_BACKOFF_EN
   localparam int BACKOFF = CP_BACKOFF;
`else
   // Window advance disabled: CP_BACKOFF has no effect on the kept indices.
   localparam int BACKOFF = CP_BACKOFF * 0;
`endif
   localparam logic [CNT_W-1:0]  LAST_DROP = CNT_W'(CP_LEN - BACKOFF - 1);
   localparam logic [CNT_W-1:0]  LAST_KEEP = CNT_W'(SYM_LEN - BACKOFF - 1);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(SYM_LEN - 1);
   localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CP        = 2'd1,
      PAYLOAD   = 2'd2,
      DROP_TAIL = 2'd3
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    smp_cnt_q;
   logic [CNT_W-1:0]    smp_cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [FILL_W-1:0]   count_q;
   logic [31:0]         mem_q [FIFO_DEPTH];

   logic full;
   logic empty;
   logic accept;
   logic push;
   logic pop;

   assign full  = (count_q == FILL_MAX);
   assign empty = (count_q == '0);

   // Gated by RST_I so the input is never acknowledged while reset is asserted.
   assign ACK_O  = RST_I & CYC_I & STB_I & WE_I & ~full;
   assign accept = CYC_I & STB_I & WE_I & ACK_O;
   assign push   = accept & (state_q == PAYLOAD);
   assign pop    = ~empty & ACK_I;

   assign smp_cnt_d = (smp_cnt_q == LAST_IDX) ? '0 : smp_cnt_q + CNT_W'(1);

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q   <= IDLE;
         smp_cnt_q <= '0;
      end else if (!CYC_I) begin
         state_q   <= IDLE;
         smp_cnt_q <= '0;
      end else if (accept) begin
         smp_cnt_q <= smp_cnt_d;
         case (state_q)
            IDLE, CP: begin
               if (smp_cnt_q == LAST_DROP) state_q <= PAYLOAD;
               else                        state_q <= CP;
            end
            PAYLOAD: begin
               if (smp_cnt_q == LAST_KEEP) begin
`ifdef CP_REM_BACKOFF_EN
                  state_q <= DROP_TAIL;
`else
                  state_q <= CP;
`endif
               end
            end
            DROP_TAIL: begin
               if (smp_cnt_q == LAST_IDX) state_q <= CP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage needs no reset: DAT_O is forced to zero whenever the FIFO is empty.
   always_ff @(posedge CLK_I) begin
      if (push) mem_q[wr_ptr_q] <= DAT_I;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + FILL_W'(1);
            2'b01:   count_q <= count_q - FILL_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign STB_O = ~empty;
   assign WE_O  = ~empty;
   assign DAT_O = empty ? 32'd0 : mem_q[rd_ptr_q];
   assign CYC_O = (state_q != IDLE) | ~empty;

endmodule
`default_nettype wire

// File: tb/tb_cp_remover.sv
`default_nettype none
// tb_cp_remover: directed self-checking bench for cp_remover (default parameters).
module tb_cp_remover;

   localparam int SYM     = 80;
   localparam int FFT_LEN = 64;
   localparam int DEPTH   = 16;
`ifdef CP_REM_BACKOFF_EN
   localparam int KF = 12;
`else
   localparam int KF = 16;
`endif

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b0;
   logic [31:0] DAT_I = '0;
   logic        WE_I  = 1'b0;
   logic        STB_I = 1'b0;
   logic        CYC_I = 1'b0;
   logic        ACK_I = 1'b0;
   logic        ACK_O;
   logic [31:0] DAT_O;
   logic        CYC_O;
   logic        STB_O;
   logic        WE_O;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] got_q[$];

   always #5 CLK_I = ~CLK_I;

   cp_remover dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .DAT_I (DAT_I),
      .WE_I  (WE_I),
      .STB_I (STB_I),
      .CYC_I (CYC_I),
      .ACK_O (ACK_O),
      .DAT_O (DAT_O),
      .CYC_O (CYC_O),
      .STB_O (STB_O),
      .WE_O  (WE_O),
      .ACK_I (ACK_I)
   );

   // Inputs change only at posedge+1, so the value seen here is what the next edge pops.
   always @(negedge CLK_I) begin
      if (STB_O === 1'b1 && ACK_I === 1'b1) got_q.push_back(DAT_O);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_sample(input logic [31:0] v);
      int guard;
      guard = 0;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = v;
      @(negedge CLK_I);
      while (ACK_O !== 1'b1 && guard < 200) begin
         @(negedge CLK_I);
         guard++;
      end
      if (ACK_O !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL input_ack_timeout: ACK_O=%b required 1 for sample %0d", ACK_O, v);
      end
      @(posedge CLK_I);
      #1;
   endtask

   task automatic go_idle(input int n);
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
      repeat (n) @(posedge CLK_I);
      #1;
   endtask

   task automatic test_reset;
      RST_I = 1'b0; ACK_I = 1'b1;
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
      repeat (3) @(posedge CLK_I);
      #1;
      n_checks++;
      if ({ACK_O, STB_O, WE_O, CYC_O} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: ACK/STB/WE/CYC=%b required 0000", {ACK_O, STB_O, WE_O, CYC_O});
      end
      n_checks++;
      if (DAT_O !== 32'd0) begin
         n_fail++; $display("FAIL reset_dat: DAT_O=%h required 0", DAT_O);
      end
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
      @(posedge CLK_I); #1;
      RST_I = 1'b1;
      repeat (2) @(posedge CLK_I);
      #1;
      n_checks++;
      if ({STB_O, CYC_O} !== 2'b00) begin
         n_fail++; $display("FAIL idle_after_reset: STB_O/CYC_O=%b required 00", {STB_O, CYC_O});
      end
   endtask

   task automatic test_single_frame;
      got_q.delete(); ACK_I = 1'b1;
      for (int i = 0; i < SYM; i++) begin
         drive_sample(32'(i));
         if (i == KF - 1) begin
            n_checks++;
            if (STB_O !== 1'b0) begin
               n_fail++; $display("FAIL early_stb: STB_O=%b required 0 after index %0d", STB_O, i);
            end
         end
         if (i == KF) begin
            n_checks++;
            if (STB_O !== 1'b1 || DAT_O !== 32'(KF)) begin
               n_fail++;
               $display("FAIL first_out_latency: STB_O=%b DAT_O=%0d required 1 and %0d", STB_O, DAT_O, KF);
            end
         end
      end
      n_checks++;
      if (CYC_O !== 1'b1) begin
         n_fail++; $display("FAIL cyc_o_active: CYC_O=%b required 1", CYC_O);
      end
      go_idle(4);
      n_checks++;
      if (got_q.size() != FFT_LEN) begin
         n_fail++; $display("FAIL frame_count: got %0d outputs required %0d", got_q.size(), FFT_LEN);
      end
      for (int k = 0; k < FFT_LEN && k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k] !== 32'(KF + k)) begin
            n_fail++; $display("FAIL frame_data[%0d]: got %0d required %0d", k, got_q[k], KF + k);
         end
      end
      n_checks++;
      if (CYC_O !== 1'b0 || STB_O !== 1'b0) begin
         n_fail++; $display("FAIL cyc_o_fall: CYC_O=%b STB_O=%b required 0 0", CYC_O, STB_O);
      end
   endtask

   task automatic test_back_to_back;
      int exp_v;
      got_q.delete(); ACK_I = 1'b1;
      for (int i = 0; i < 2 * SYM; i++) drive_sample(32'(i));
      go_idle(4);
      n_checks++;
      if (got_q.size() != 2 * FFT_LEN) begin
         n_fail++; $display("FAIL b2b_count: got %0d outputs required %0d", got_q.size(), 2 * FFT_LEN);
      end
      for (int k = 0; k < 2 * FFT_LEN && k < got_q.size(); k++) begin
         exp_v = (k < FFT_LEN) ? (KF + k) : (SYM + KF + k - FFT_LEN);
         n_checks++;
         if (got_q[k] !== 32'(exp_v)) begin
            n_fail++; $display("FAIL b2b_data[%0d]: got %0d required %0d", k, got_q[k], exp_v);
         end
      end
   endtask

   task automatic test_backpressure;
      got_q.delete(); ACK_I = 1'b0;
      for (int i = 0; i < KF + DEPTH; i++) drive_sample(32'(i));
      DAT_I = 32'(KF + DEPTH);
      repeat (3) @(posedge CLK_I);
      #1;
      n_checks++;
      if (ACK_O !== 1'b0) begin
         n_fail++; $display("FAIL full_stall: ACK_O=%b required 0", ACK_O);
      end
      n_checks++;
      if (STB_O !== 1'b1 || DAT_O !== 32'(KF)) begin
         n_fail++; $display("FAIL head_hold: STB_O=%b DAT_O=%0d required 1 and %0d", STB_O, DAT_O, KF);
      end
      n_checks++;
      if (got_q.size() != 0) begin
         n_fail++; $display("FAIL no_pop_while_held: got %0d pops required 0", got_q.size());
      end
      ACK_I = 1'b1;
      for (int i = KF + DEPTH; i < SYM; i++) drive_sample(32'(i));
      go_idle(DEPTH + 4);
      n_checks++;
      if (got_q.size() != FFT_LEN) begin
         n_fail++; $display("FAIL bp_count: got %0d outputs required %0d", got_q.size(), FFT_LEN);
      end
      for (int k = 0; k < FFT_LEN && k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k] !== 32'(KF + k)) begin
            n_fail++; $display("FAIL bp_data[%0d]: got %0d required %0d", k, got_q[k], KF + k);
         end
      end
   endtask

   task automatic test_cyc_drop;
      got_q.delete(); ACK_I = 1'b1;
      for (int i = 0; i < 40; i++) drive_sample(32'(i));
      go_idle(4);
      n_checks++;
      if (got_q.size() != 40 - KF) begin
         n_fail++; $display("FAIL partial_count: got %0d outputs required %0d", got_q.size(), 40 - KF);
      end
      for (int k = 0; k < 40 - KF && k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k] !== 32'(KF + k)) begin
            n_fail++; $display("FAIL partial_data[%0d]: got %0d required %0d", k, got_q[k], KF + k);
         end
      end
      got_q.delete();
      for (int i = 0; i < SYM; i++) drive_sample(32'(1000 + i));
      go_idle(4);
      n_checks++;
      if (got_q.size() != FFT_LEN) begin
         n_fail++; $display("FAIL restart_count: got %0d outputs required %0d", got_q.size(), FFT_LEN);
      end
      for (int k = 0; k < FFT_LEN && k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k] !== 32'(1000 + KF + k)) begin
            n_fail++; $display("FAIL restart_data[%0d]: got %0d required %0d", k, got_q[k], 1000 + KF + k);
         end
      end
   endtask

   task automatic test_reset_mid;
      got_q.delete(); ACK_I = 1'b0;
      for (int i = 0; i < KF + 5; i++) drive_sample(32'(i));
      DAT_I = 32'(KF + 5);
      n_checks++;
      if ({STB_O, CYC_O, ACK_O} !== 3'b111) begin
         n_fail++; $display("FAIL pre_reset: STB/CYC/ACK=%b required 111", {STB_O, CYC_O, ACK_O});
      end
      #2 RST_I = 1'b0;
      #1;
      n_checks++;
      if ({STB_O, CYC_O, ACK_O, WE_O} !== 4'b0000) begin
         n_fail++; $display("FAIL async_reset_ctrl: STB/CYC/ACK/WE=%b required 0000", {STB_O, CYC_O, ACK_O, WE_O});
      end
      n_checks++;
      if (DAT_O !== 32'd0) begin
         n_fail++; $display("FAIL async_reset_dat: DAT_O=%h required 0", DAT_O);
      end
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0; ACK_I = 1'b1;
      @(posedge CLK_I); #1;
      RST_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      #1;
      n_checks++;
      if ({STB_O, CYC_O} !== 2'b00 || got_q.size() != 0) begin
         n_fail++;
         $display("FAIL post_reset_empty: STB/CYC=%b pops=%0d required 00 and 0", {STB_O, CYC_O}, got_q.size());
      end
      for (int i = 0; i < SYM; i++) drive_sample(32'(2000 + i));
      go_idle(4);
      n_checks++;
      if (got_q.size() != FFT_LEN) begin
         n_fail++; $display("FAIL post_reset_count: got %0d outputs required %0d", got_q.size(), FFT_LEN);
      end else begin
         n_checks++;
         if (got_q[0] !== 32'(2000 + KF) || got_q[FFT_LEN-1] !== 32'(2000 + KF + FFT_LEN - 1)) begin
            n_fail++;
            $display("FAIL post_reset_data: first %0d last %0d required %0d and %0d",
                     got_q[0], got_q[FFT_LEN-1], 2000 + KF, 2000 + KF + FFT_LEN - 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_cyc_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
